// File: rtl/fpu_alu_pkg.sv
// Shared definitions for the limb-serial FPU mantissa ALU: opcode values and FSM state encodings.
package fpu_alu_pkg;

  localparam logic FPU_OP_ADD = 1'b0;
  localparam logic FPU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

endpackage

// File: rtl/fpu_limb_adder.sv
// One LIMB-bit slice of the serial adder: sum = x + (invert_y ? ~y : y) + cin.
// Latency: combinational. Backpressure: none, pure datapath.
// Carry-out feeds the registered carry/borrow chain in the parent.
module fpu_limb_adder #(
  parameter int LIMB = 16
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic            invert_y,
  input  logic            cin,
  output logic [LIMB-1:0] sum,
  output logic            cout
);

  logic [LIMB-1:0] y_eff;

  assign y_eff       = invert_y ? ~y : y;
  assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/fpu_serial_big_alu.sv
// Limb-serial sign-magnitude add/subtract of two WIDTH-bit magnitudes (optional result_zero: FPU_SERIAL_ALU_ZERO_FLAG_EN).
// Latency: NLIMBS cycles accept->out_valid, 2*NLIMBS when the magnitude must be negated.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fpu_serial_big_alu
  import fpu_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LIMB  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_sign,
  input  logic             b_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   extended_result,
  output logic             result_sign
`ifdef FPU_SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             result_zero
`endif
);

  localparam int NLIMBS = WIDTH / LIMB;
  localparam int CW     = $clog2(NLIMBS) + 1;

  if (LIMB < 1 || WIDTH % LIMB != 0) begin : g_bad_cfg
    $error("fpu_serial_big_alu: WIDTH must be a non-zero multiple of LIMB");
  end

  alu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, mag_q, mag_full;
  logic             carry_q, eff_sub_q, a_sign_q, b_sign_q, op_q;
  int               base;
  logic             first_limb, last_limb;

  logic [LIMB-1:0]  add_x, add_y, limb_sum;
  logic             add_inv, add_cin, limb_cout;

  logic             go_neg, done_load, res_zero, res_sign;
  logic [WIDTH:0]   res_ext;

  assign base       = int'(cnt_q) * LIMB;
  assign first_limb = (cnt_q == '0);
  assign last_limb  = (cnt_q == CW'(NLIMBS - 1));

  // RUN adds a + (b or ~b); NEG reuses the same slice to form 0 + ~mag + 1.
  always_comb begin
    add_x   = a_q[base +: LIMB];
    add_y   = b_q[base +: LIMB];
    add_inv = eff_sub_q;
    add_cin = first_limb ? eff_sub_q : carry_q;
    if (state_q == ST_NEG) begin
      add_x   = '0;
      add_y   = mag_q[base +: LIMB];
      add_inv = 1'b1;
      add_cin = first_limb ? 1'b1 : carry_q;
    end
  end

  fpu_limb_adder #(.LIMB(LIMB)) u_limb_adder (
    .x        (add_x),
    .y        (add_y),
    .invert_y (add_inv),
    .cin      (add_cin),
    .sum      (limb_sum),
    .cout     (limb_cout)
  );

  always_comb begin
    mag_full                  = mag_q;
    mag_full[base +: LIMB]    = limb_sum;
  end

  // No carry-out on the last subtract limb means a < b: magnitude is negative.
  assign go_neg    = eff_sub_q & ~limb_cout;
  assign done_load = ((state_q == ST_RUN) && last_limb && !go_neg) ||
                     ((state_q == ST_NEG) && last_limb);
  assign res_ext   = {((state_q == ST_RUN) && !eff_sub_q) ? limb_cout : 1'b0, mag_full};
  assign res_zero  = ~|res_ext;
  assign res_sign  = ((state_q == ST_NEG) ? (b_sign_q ^ (op_q == FPU_OP_SUB)) : a_sign_q) & ~res_zero;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_limb) state_d = go_neg ? ST_NEG : ST_DONE;
      end
      ST_NEG: begin
        if (last_limb) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      carry_q         <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      mag_q           <= '0;
      eff_sub_q       <= 1'b0;
      a_sign_q        <= 1'b0;
      b_sign_q        <= 1'b0;
      op_q            <= 1'b0;
      extended_result <= '0;
      result_sign     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            a_sign_q  <= a_sign;
            b_sign_q  <= b_sign;
            op_q      <= op;
            eff_sub_q <= a_sign ^ b_sign ^ (op == FPU_OP_SUB);
            cnt_q     <= '0;
            carry_q   <= 1'b0;
          end
        end
        ST_RUN, ST_NEG: begin
          mag_q   <= mag_full;
          carry_q <= limb_cout;
          cnt_q   <= last_limb ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
      if (done_load) begin
        extended_result <= res_ext;
        result_sign     <= res_sign;
      end
    end
  end

`ifdef FPU_SERIAL_ALU_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)            result_zero <= 1'b0;
    else if (done_load) result_zero <= res_zero;
  end
`endif

endmodule
